// File: rtl/register_5bit_en_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : register_5bit_en_pkg
//  Purpose  : Shared constants and the data type for the 5-bit enabled
//             holding register and its bit-slice flop.
//  Contents : REG5_WIDTH - default data width
//             REG5_RESET - default reset value
//             reg5_t     - default-width data type
//  Revision : 1.0 - initial release
// ============================================================================
package register_5bit_en_pkg;

    localparam int unsigned REG5_WIDTH = 5;

    typedef logic [REG5_WIDTH-1:0] reg5_t;

    localparam reg5_t REG5_RESET = 5'b00000;

endpackage : register_5bit_en_pkg
`default_nettype wire

// File: rtl/register_5bit_en_dff_en_arst.sv
`default_nettype none
// ============================================================================
//  Module   : dff_en_arst
//  Purpose  : Single-bit flop with a synchronous load enable and an
//             asynchronous active-low clear to a configurable value.
//  Ports    : clk_i  - rising-edge clock
//             rst_ni - asynchronous reset, active low
//             en_i   - load enable, active high
//             d_i    - data to capture when enabled
//             q_o    - flop output
//  Revision : 1.0 - initial release
// ============================================================================
module dff_en_arst #(
    parameter logic RESET_BIT = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic d_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    // Hold unless enabled; the reset branch below overrides everything.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_q <= RESET_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : dff_en_arst
`default_nettype wire

// File: rtl/register_5bit_en.sv
`default_nettype none
// ============================================================================
//  Module   : register_5bit_en
//  Purpose  : Parameterised holding register (default 5 bits). Captures
//             data_in on a rising clk edge when write_en is high, holds
//             otherwise, and clears asynchronously while rst is low.
//             data_out comes straight from the flops.
//  Ports    : clk      - rising-edge clock
//             rst      - asynchronous reset, active low (0 = in reset)
//             data_in  - WIDTH-bit data to store
//             write_en - synchronous load enable, active high
//             data_out - WIDTH-bit register contents
//  Revision : 1.0 - initial release
// ============================================================================
module register_5bit_en
    import register_5bit_en_pkg::*;
#(
    parameter int unsigned      WIDTH       = REG5_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             write_en,
    output logic [WIDTH-1:0] data_out
);

    // One flop per bit; each bit clears to its own slice of RESET_VALUE so
    // arbitrary reset patterns are supported without extra muxing.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_en_arst #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_dff (
            .clk_i  (clk),
            .rst_ni (rst),
            .en_i   (write_en),
            .d_i    (data_in[i]),
            .q_o    (data_out[i])
        );
    end : g_bit

endmodule : register_5bit_en
`default_nettype wire

// File: tb/tb_register_5bit_en.sv
`default_nettype none
// ============================================================================
//  Module   : tb_register_5bit_en
//  Purpose  : Self-checking bench for register_5bit_en. Stimulus applies one
//             vector per cycle just after the rising edge and queues the
//             expected register value; a monitor samples data_out on each
//             falling edge and compares against the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_register_5bit_en;
    import register_5bit_en_pkg::*;

    typedef struct {
        reg5_t v;
        string tag;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b0;
    reg5_t data_in = '0;
    logic  write_en = 1'b0;
    reg5_t data_out;

    exp_t  exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    // Reference state and the inputs the DUT will see at the next edge.
    reg5_t model = 5'b00000;
    logic  p_rst = 1'b0;
    logic  p_we  = 1'b0;
    reg5_t p_din = 5'b00000;

    register_5bit_en dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .write_en (write_en),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Advance the model across the edge, apply new inputs 1 time unit later
    // and queue the value data_out must show at the following falling edge
    // (i.e. before the next rising edge captures these inputs).
    task automatic apply(input logic r, input logic we, input reg5_t d,
                         input string tag);
        exp_t e;
        @(posedge clk);
        if (!p_rst)     model = 5'b00000;
        else if (p_we)  model = p_din;
        #1;
        rst      = r;
        write_en = we;
        data_in  = d;
        if (!r) model = 5'b00000;
        p_rst = r;
        p_we  = we;
        p_din = d;
        e.v   = model;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (data_out !== e.v) begin
                    n_bad++;
                    $display("FAIL %s @%0t: data_out=%b expected=%b",
                             e.tag, $time, data_out, e.v);
                end
            end
        end
    end

    // Stimulus
    initial begin
        reg5_t rd;
        logic  rr;
        logic  rw;
        int    guard;

        // Reset state
        apply(1'b0, 1'b0, 5'b00000, "reset_init");
        apply(1'b0, 1'b1, 5'b11111, "reset_init_hold");
        apply(1'b1, 1'b1, 5'b10110, "release_load_pre");
        apply(1'b1, 1'b0, 5'b00000, "release_load_post");   // data_out = 10110

        // Mid-cycle reset clears immediately and holds for 3 edges
        apply(1'b0, 1'b1, 5'b11111, "async_clear");
        apply(1'b0, 1'b1, 5'b11111, "reset_hold1");
        apply(1'b0, 1'b1, 5'b11111, "reset_hold2");
        apply(1'b0, 1'b1, 5'b11111, "reset_hold3");

        // Load: unchanged before edge N, new value after it
        apply(1'b1, 1'b1, 5'b01101, "load_before_edge");
        // Hold for 4 edges
        apply(1'b1, 1'b0, 5'b10010, "load_after_edge");
        apply(1'b1, 1'b0, 5'b10010, "hold1");
        apply(1'b1, 1'b0, 5'b10010, "hold2");
        apply(1'b1, 1'b0, 5'b10010, "hold3");

        // Priority: reset over write at the same edge, then release and write
        apply(1'b0, 1'b1, 5'b11111, "priority_rst");
        apply(1'b0, 1'b1, 5'b11111, "priority_rst_edge");
        apply(1'b1, 1'b1, 5'b11111, "release_write");
        apply(1'b1, 1'b0, 5'b00000, "release_write_done");

        // Back-to-back writes
        apply(1'b1, 1'b1, 5'b00001, "b2b_0");
        apply(1'b1, 1'b1, 5'b00010, "b2b_1");
        apply(1'b1, 1'b1, 5'b00100, "b2b_2");
        apply(1'b1, 1'b0, 5'b11000, "b2b_3");
        apply(1'b1, 1'b0, 5'b11000, "b2b_hold");

        // Randomised, with all-ones and all-zeros forced in
        for (int i = 0; i < 30; i++) begin
            rd = reg5_t'($urandom_range(0, 31));
            rr = ($urandom_range(0, 4) != 0);
            rw = ($urandom_range(0, 2) != 0);
            if (i == 3)  begin rd = 5'b11111; rr = 1'b1; rw = 1'b1; end
            if (i == 5)  begin rd = 5'b00000; rr = 1'b1; rw = 1'b1; end
            if (i == 9)  begin rd = 5'b11111; rr = 1'b1; rw = 1'b1; end
            apply(rr, rw, rd, "random");
        end
        apply(1'b1, 1'b0, 5'b00000, "final");

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected values left, required 0",
                     exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_register_5bit_en
`default_nettype wire
